// File: rtl/elevator_pkg.sv
// Shared elevator constants: floor codes, car move codes, dispatcher state and direction types.
// Used by both the call dispatcher and the car state machine.
package elevator_pkg;

  typedef logic [1:0] floor_t;

  localparam floor_t FLOOR_1 = 2'b00;
  localparam floor_t FLOOR_2 = 2'b01;
  localparam floor_t FLOOR_3 = 2'b10;
  localparam floor_t FLOOR_4 = 2'b11;

  // Car motion as {moving_up, moving_down}
  localparam logic [1:0] UP   = 2'b10;
  localparam logic [1:0] DOWN = 2'b01;
  localparam logic [1:0] STOP = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StTravel,
    StDoor
  } disp_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/call_dispatcher_if.sv
// Button panel / car signals seen by the call dispatcher.
// The master side is the panel plus car; the slave side is the dispatcher.
interface call_dispatcher_if;
  logic [3:0] btn;
  logic [1:0] floor_now;
  logic       moving_up;
  logic       moving_down;
  logic [1:0] req_floor;
  logic [3:0] pending;
  logic       door_open;
  logic       busy;
  logic       fault;

  modport master (
    output btn, floor_now, moving_up, moving_down,
    input  req_floor, pending, door_open, busy, fault
  );

  modport slave (
    input  btn, floor_now, moving_up, moving_down,
    output req_floor, pending, door_open, busy, fault
  );
endinterface

// File: rtl/call_selector.sv
// Picks the nearest pending floor in the current direction, reversing when
// nothing is pending ahead. Purely combinational.
module call_selector
  import elevator_pkg::*;
(
  input  logic [3:0] i_pending,
  input  floor_t     i_floor_now,
  input  dir_e       i_dir,
  output floor_t     o_target,
  output logic       o_found,
  output dir_e       o_dir
);

  logic   w_up_found;
  logic   w_dn_found;
  floor_t w_up_tgt;
  floor_t w_dn_tgt;

  always_comb begin
    w_up_found = 1'b0;
    w_up_tgt   = i_floor_now;
    w_dn_found = 1'b0;
    w_dn_tgt   = i_floor_now;
    // Scan order makes the last hit the one closest to the car.
    for (int i = 3; i >= 0; i--) begin
      if (i > int'(i_floor_now) && i_pending[i]) begin
        w_up_found = 1'b1;
        w_up_tgt   = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i < int'(i_floor_now) && i_pending[i]) begin
        w_dn_found = 1'b1;
        w_dn_tgt   = 2'(i);
      end
    end
  end

  always_comb begin
    o_found  = w_up_found | w_dn_found;
    o_target = i_floor_now;
    o_dir    = i_dir;
    if (i_dir == DIR_UP) begin
      if (w_up_found) begin
        o_target = w_up_tgt;
      end else if (w_dn_found) begin
        o_target = w_dn_tgt;
        o_dir    = DIR_DOWN;
      end
    end else begin
      if (w_dn_found) begin
        o_target = w_dn_tgt;
      end else if (w_up_found) begin
        o_target = w_up_tgt;
        o_dir    = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/call_dispatcher.sv
// Latches floor calls, steers the car toward one target at a time, runs the door
// dwell on arrival and flags a sticky fault if the car never arrives.
module call_dispatcher
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES    = 8,
  parameter int unsigned TRAVEL_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  call_dispatcher_if.slave  bus
);

  localparam int unsigned DwellW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam int unsigned WdW    = (TRAVEL_TIMEOUT > 1) ? $clog2(TRAVEL_TIMEOUT) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DOOR_CYCLES - 1);
  localparam logic [WdW-1:0]    WdLast    = WdW'(TRAVEL_TIMEOUT - 1);

  disp_state_e       r_state;
  dir_e              r_dir;
  floor_t            r_target;
  floor_t            r_req_floor;
  logic [3:0]        r_pending;
  logic              r_door_open;
  logic              r_busy;
  logic              r_fault;
  logic [DwellW-1:0] r_dwell;
  logic [WdW-1:0]    r_wd;

  logic [3:0] w_here_mask;
  logic [3:0] w_target_mask;
  logic [3:0] w_btn_latch;
  logic [3:0] w_clear;
  logic       w_arrive;
  logic       w_btn_here;
  floor_t     w_sel_target;
  logic       w_sel_found;
  dir_e       w_sel_dir;

  call_selector u_call_selector (
    .i_pending   (r_pending),
    .i_floor_now (bus.floor_now),
    .i_dir       (r_dir),
    .o_target    (w_sel_target),
    .o_found     (w_sel_found),
    .o_dir       (w_sel_dir)
  );

  assign w_here_mask   = 4'b0001 << bus.floor_now;
  assign w_target_mask = 4'b0001 << r_target;
  // Both move bits high is illegal and counts as still moving.
  assign w_arrive      = (r_state == StTravel) && (bus.floor_now == r_target) &&
                         ({bus.moving_up, bus.moving_down} == STOP);
  assign w_btn_here    = (r_state == StDoor) && |(bus.btn & w_here_mask);
  assign w_btn_latch   = (r_state == StDoor) ? (bus.btn & ~w_here_mask) : bus.btn;

  always_comb begin
    w_clear = 4'b0000;
    if (r_state == StIdle && |(r_pending & w_here_mask)) begin
      w_clear = w_here_mask;
    end else if (w_arrive) begin
      w_clear = w_target_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_dir       <= DIR_UP;
      r_target    <= FLOOR_1;
      r_req_floor <= FLOOR_1;
      r_pending   <= 4'b0000;
      r_door_open <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
      r_dwell     <= '0;
      r_wd        <= '0;
    end else begin
      // Clear wins over a same-edge press for the serviced floor.
      r_pending <= (r_pending | w_btn_latch) & ~w_clear;
      unique case (r_state)
        StIdle: begin
          r_req_floor <= bus.floor_now;
          if (|(r_pending & w_here_mask)) begin
            r_state     <= StDoor;
            r_door_open <= 1'b1;
            r_busy      <= 1'b1;
            r_dwell     <= '0;
          end else if (w_sel_found) begin
            r_state     <= StTravel;
            r_target    <= w_sel_target;
            r_req_floor <= w_sel_target;
            r_dir       <= w_sel_dir;
            r_busy      <= 1'b1;
            r_wd        <= '0;
          end
        end
        StTravel: begin
          if (w_arrive) begin
            r_state     <= StDoor;
            r_door_open <= 1'b1;
            r_dwell     <= '0;
          end else if (r_wd == WdLast) begin
            r_state     <= StIdle;
            r_fault     <= 1'b1;
            r_req_floor <= bus.floor_now;
            r_busy      <= 1'b0;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        StDoor: begin
          if (w_btn_here) begin
            r_dwell <= '0;
          end else if (r_dwell == DwellLast) begin
            r_state     <= StIdle;
            r_door_open <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_door_open <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_floor = r_req_floor;
  assign bus.pending   = r_pending;
  assign bus.door_open = r_door_open;
  assign bus.busy      = r_busy;
  assign bus.fault     = r_fault;

endmodule
